// File: rtl/rob_wide.sv
// Reorder buffer: in-order retire of up to two entries per cycle,
// multi-port writeback, operand bypass and mispredict flush.
module rob_wide #(
    parameter  int DEPTH    = 16,
    parameter  int WB_PORTS = 2,
    parameter  int SLACK    = 3,
    localparam int IDW      = $clog2(DEPTH)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    output logic                     rob_clear,
    output logic [31:0]              new_pc,
    output logic                     rob_empty,
    output logic                     rob_full,
    output logic [IDW-1:0]           rob_free_id,
    output logic [IDW-1:0]           rob_head_id,
    input  logic                     issue_valid,
    input  logic [31:0]              issue_pc,
    input  logic                     issue_done,
    input  logic [31:0]              issue_result,
    input  logic [4:0]               issue_rd,
    input  logic [1:0]               issue_type,
    input  logic                     issue_pred,
    input  logic [31:0]              issue_alt_pc,
    input  logic [WB_PORTS-1:0]      wb_valid,
    input  logic [WB_PORTS*IDW-1:0]  wb_id,
    input  logic [WB_PORTS*32-1:0]   wb_val,
    output logic [4:0]               dep_rd,
    output logic [IDW-1:0]           dep_tag,
    output logic [1:0]               cm_valid,
    output logic [9:0]               cm_rd,
    output logic [63:0]              cm_val,
    output logic [2*IDW-1:0]         cm_id,
    input  logic [2*IDW-1:0]         q_id,
    output logic [1:0]               q_avail,
    output logic [63:0]              q_val,
    output logic                     br_valid,
    output logic [7:0]               br_pc_part,
    output logic                     br_taken
);

    localparam logic [IDW:0] LP_DEPTH = (IDW+1)'(DEPTH);
    localparam logic [IDW:0] LP_FULL  = (IDW+1)'(DEPTH - 1 - SLACK);

    logic [IDW-1:0]   r_head;
    logic [IDW-1:0]   r_tail;
    logic [IDW:0]     r_count;
    logic             r_clear;
    logic [31:0]      r_new_pc;
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] r_ready;
    logic [DEPTH-1:0] r_pred;
    logic [31:0]      r_val  [DEPTH];
    logic [31:0]      r_alt  [DEPTH];
    logic [4:0]       r_rd   [DEPTH];
    logic [1:0]       r_type [DEPTH];
    logic [7:0]       r_pcp  [DEPTH];

    logic [IDW-1:0]   w_wb_id  [WB_PORTS];
    logic [31:0]      w_wb_val [WB_PORTS];
    logic             w_act;
    logic [IDW-1:0]   w_h0;
    logic [IDW-1:0]   w_h1;
    logic             w_br0;
    logic             w_br1;
    logic             w_c0;
    logic             w_c1;
    logic [1:0]       w_ncm;
    logic             w_issue;
    logic             w_br_valid;
    logic [IDW-1:0]   w_br_id;
    logic             w_mis;
    logic             w_unused_pc;

    for (genvar g = 0; g < WB_PORTS; g++) begin : g_wb
        assign w_wb_id[g]  = wb_id[g*IDW +: IDW];
        assign w_wb_val[g] = wb_val[g*32 +: 32];
    end

    assign w_unused_pc = ^{issue_pc[31:9], issue_pc[0]};

    // clear cycle: entries are wrong-path, nothing may retire or enter
    assign w_act   = rdy_in & ~r_clear;
    assign w_h0    = r_head;
    assign w_h1    = r_head + IDW'(1);
    assign w_br0   = (r_type[w_h0] == 2'b10);
    assign w_br1   = (r_type[w_h1] == 2'b10);
    assign w_c0    = w_act & r_busy[w_h0] & r_ready[w_h0];
    assign w_c1    = w_c0 & r_busy[w_h1] & r_ready[w_h1] & ~w_br0;
    assign w_ncm   = {1'b0, w_c0} + {1'b0, w_c1};
    assign w_issue = issue_valid & w_act & (r_count < LP_DEPTH);

    assign w_br_valid = (w_c0 & w_br0) | (w_c1 & w_br1);
    assign w_br_id    = (w_c0 & w_br0) ? w_h0 : w_h1;
    assign w_mis      = w_br_valid & (r_val[w_br_id][0] != r_pred[w_br_id]);

    assign rob_clear   = r_clear;
    assign new_pc      = r_new_pc;
    assign rob_empty   = rdy_in & (r_count == '0);
    assign rob_full    = rdy_in & (r_count > LP_FULL);
    assign rob_free_id = r_tail;
    assign rob_head_id = r_head;
    assign dep_rd      = (rdy_in & issue_valid & issue_type[0]) ? issue_rd : 5'd0;
    assign dep_tag     = rdy_in ? r_tail : '0;
    assign cm_valid    = {w_c1, w_c0};
    assign br_valid    = w_br_valid;
    assign br_pc_part  = w_br_valid ? r_pcp[w_br_id] : 8'd0;
    assign br_taken    = w_br_valid & r_val[w_br_id][0];

    always_comb begin
        cm_rd  = '0;
        cm_val = '0;
        cm_id  = '0;
        if (w_c0) begin
            cm_rd[4:0]       = r_type[w_h0][0] ? r_rd[w_h0] : 5'd0;
            cm_val[31:0]     = r_val[w_h0];
            cm_id[IDW-1:0]   = w_h0;
        end
        if (w_c1) begin
            cm_rd[9:5]       = r_type[w_h1][0] ? r_rd[w_h1] : 5'd0;
            cm_val[63:32]    = r_val[w_h1];
            cm_id[2*IDW-1:IDW] = w_h1;
        end
    end

    // stored value first; descending scan leaves the lowest channel
    always_comb begin
        q_avail = '0;
        q_val   = '0;
        if (rdy_in) begin
            for (int j = 0; j < 2; j++) begin
                if (r_busy[q_id[j*IDW +: IDW]] && r_ready[q_id[j*IDW +: IDW]]) begin
                    q_avail[j]        = 1'b1;
                    q_val[j*32 +: 32] = r_val[q_id[j*IDW +: IDW]];
                end else begin
                    for (int k = WB_PORTS - 1; k >= 0; k--) begin
                        if (wb_valid[k] && w_wb_id[k] == q_id[j*IDW +: IDW]
                            && r_busy[q_id[j*IDW +: IDW]]) begin
                            q_avail[j]        = 1'b1;
                            q_val[j*32 +: 32] = w_wb_val[k];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_busy   <= '0;
            r_ready  <= '0;
            r_clear  <= 1'b0;
            r_new_pc <= '0;
        end else if (rdy_in) begin
            if (r_clear) begin
                r_head   <= '0;
                r_tail   <= '0;
                r_count  <= '0;
                r_busy   <= '0;
                r_ready  <= '0;
                r_clear  <= 1'b0;
                r_new_pc <= '0;
            end else begin
                for (int k = 0; k < WB_PORTS; k++) begin
                    if (wb_valid[k] && r_busy[w_wb_id[k]]) begin
                        r_ready[w_wb_id[k]] <= 1'b1;
                    end
                end
                if (w_c0) begin
                    r_busy[w_h0]  <= 1'b0;
                    r_ready[w_h0] <= 1'b0;
                end
                if (w_c1) begin
                    r_busy[w_h1]  <= 1'b0;
                    r_ready[w_h1] <= 1'b0;
                end
                if (w_issue) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_ready[r_tail] <= issue_done;
                    r_tail          <= r_tail + IDW'(1);
                end
                r_head  <= r_head + IDW'(w_ncm);
                r_count <= r_count + (IDW+1)'(w_issue) - (IDW+1)'(w_ncm);
                r_clear <= w_mis;
                if (w_mis) begin
                    r_new_pc <= r_alt[w_br_id];
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_act) begin
            for (int k = 0; k < WB_PORTS; k++) begin
                if (wb_valid[k] && r_busy[w_wb_id[k]]) begin
                    r_val[w_wb_id[k]] <= w_wb_val[k];
                end
            end
            if (w_issue) begin
                r_val[r_tail]  <= issue_result;
                r_alt[r_tail]  <= issue_alt_pc;
                r_rd[r_tail]   <= issue_rd;
                r_type[r_tail] <= issue_type;
                r_pred[r_tail] <= issue_pred;
                r_pcp[r_tail]  <= issue_pc[8:1];
            end
        end
    end

endmodule

// File: tb/tb_rob_wide.sv
// Bench for rob_wide: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rob_wide;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_clear;
    logic [31:0] new_pc;
    logic        rob_empty;
    logic        rob_full;
    logic [3:0]  rob_free_id;
    logic [3:0]  rob_head_id;
    logic        issue_valid;
    logic [31:0] issue_pc;
    logic        issue_done;
    logic [31:0] issue_result;
    logic [4:0]  issue_rd;
    logic [1:0]  issue_type;
    logic        issue_pred;
    logic [31:0] issue_alt_pc;
    logic [1:0]  wb_valid;
    logic [7:0]  wb_id;
    logic [63:0] wb_val;
    logic [4:0]  dep_rd;
    logic [3:0]  dep_tag;
    logic [1:0]  cm_valid;
    logic [9:0]  cm_rd;
    logic [63:0] cm_val;
    logic [7:0]  cm_id;
    logic [7:0]  q_id;
    logic [1:0]  q_avail;
    logic [63:0] q_val;
    logic        br_valid;
    logic [7:0]  br_pc_part;
    logic        br_taken;

    always #5 clk = ~clk;

    rob_wide #(.DEPTH(16), .WB_PORTS(2), .SLACK(3)) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .rob_clear(rob_clear), .new_pc(new_pc),
        .rob_empty(rob_empty), .rob_full(rob_full),
        .rob_free_id(rob_free_id), .rob_head_id(rob_head_id),
        .issue_valid(issue_valid), .issue_pc(issue_pc),
        .issue_done(issue_done), .issue_result(issue_result),
        .issue_rd(issue_rd), .issue_type(issue_type),
        .issue_pred(issue_pred), .issue_alt_pc(issue_alt_pc),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_val(wb_val),
        .dep_rd(dep_rd), .dep_tag(dep_tag),
        .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_val(cm_val), .cm_id(cm_id),
        .q_id(q_id), .q_avail(q_avail), .q_val(q_val),
        .br_valid(br_valid), .br_pc_part(br_pc_part), .br_taken(br_taken)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [1:0]  typ;
        logic        pred;
        logic [31:0] alt;
        logic [7:0]  pcp;
        logic        rdy;
        logic [31:0] val;
    } ent_t;

    ent_t        mq[$];
    int          mhead = 0;
    logic        mclear = 1'b0;
    logic [31:0] mnpc = '0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, a, e);
        end
    endtask

    // reference model: queue of live entries, oldest first
    always @(negedge clk) begin
        automatic int          sz;
        automatic int          bi;
        automatic int          pos;
        automatic int          t;
        automatic bit          act, c0, c1, bv, mis, hit;
        automatic logic [9:0]  e_rd = '0;
        automatic logic [63:0] e_val = '0;
        automatic logic [7:0]  e_id = '0;
        automatic logic [1:0]  e_qa = '0;
        automatic logic [63:0] e_qv = '0;
        automatic logic [31:0] e_alt = '0;
        automatic logic [7:0]  e_pcp = '0;
        automatic logic        e_tk = 1'b0;
        if (rst_in) begin
            mq.delete();
            mhead  = 0;
            mclear = 1'b0;
            mnpc   = '0;
        end
        sz  = mq.size();
        act = rdy_in && !mclear;
        c0  = act && sz >= 1 && mq[0].rdy;
        c1  = c0 && sz >= 2 && mq[1].rdy && mq[0].typ != 2'b10;
        if (c0) begin
            e_rd[4:0]   = mq[0].typ[0] ? mq[0].rd : 5'd0;
            e_val[31:0] = mq[0].val;
            e_id[3:0]   = 4'(mhead);
        end
        if (c1) begin
            e_rd[9:5]    = mq[1].typ[0] ? mq[1].rd : 5'd0;
            e_val[63:32] = mq[1].val;
            e_id[7:4]    = 4'((mhead + 1) % 16);
        end
        bv = 0;
        bi = 0;
        if (c0 && mq[0].typ == 2'b10) bv = 1;
        else if (c1 && mq[1].typ == 2'b10) begin bv = 1; bi = 1; end
        mis = 0;
        if (bv) begin
            mis   = (mq[bi].val[0] != mq[bi].pred);
            e_alt = mq[bi].alt;
            e_pcp = mq[bi].pcp;
            e_tk  = mq[bi].val[0];
        end
        for (int j = 0; j < 2; j++) begin
            t   = int'(q_id[j*4 +: 4]);
            pos = (t - mhead + 16) % 16;
            if (rdy_in && pos < sz) begin
                if (mq[pos].rdy) begin
                    e_qa[j] = 1'b1;
                    e_qv[j*32 +: 32] = mq[pos].val;
                end else begin
                    hit = 0;
                    for (int k = 0; k < 2; k++) begin
                        if (!hit && wb_valid[k] && int'(wb_id[k*4 +: 4]) == t) begin
                            hit = 1;
                            e_qa[j] = 1'b1;
                            e_qv[j*32 +: 32] = wb_val[k*32 +: 32];
                        end
                    end
                end
            end
        end
        chk("empty", 64'(rob_empty), 64'(rdy_in && sz == 0));
        chk("full", 64'(rob_full), 64'(rdy_in && sz > 12));
        chk("free_id", 64'(rob_free_id), 64'((mhead + sz) % 16));
        chk("head_id", 64'(rob_head_id), 64'(mhead));
        chk("rob_clear", 64'(rob_clear), 64'(mclear));
        chk("new_pc", 64'(new_pc), 64'(mnpc));
        chk("dep_rd", 64'(dep_rd),
            64'((rdy_in && issue_valid && issue_type[0]) ? issue_rd : 5'd0));
        chk("dep_tag", 64'(dep_tag), rdy_in ? 64'((mhead + sz) % 16) : 64'd0);
        chk("cm_valid", 64'(cm_valid), 64'({c1, c0}));
        chk("cm_rd", 64'(cm_rd), 64'(e_rd));
        chk("cm_val", cm_val, e_val);
        chk("cm_id", 64'(cm_id), 64'(e_id));
        chk("q_avail", 64'(q_avail), 64'(e_qa));
        chk("q_val", q_val, e_qv);
        chk("br_valid", 64'(br_valid), 64'(bv));
        chk("br_pc_part", 64'(br_pc_part), 64'(e_pcp));
        chk("br_taken", 64'(br_taken), 64'(e_tk));
        if (!rst_in && rdy_in) begin
            if (mclear) begin
                mq.delete();
                mhead  = 0;
                mclear = 1'b0;
                mnpc   = '0;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (wb_valid[k]) begin
                        pos = (int'(wb_id[k*4 +: 4]) - mhead + 16) % 16;
                        if (pos < sz) begin
                            mq[pos].rdy = 1'b1;
                            mq[pos].val = wb_val[k*32 +: 32];
                        end
                    end
                end
                if (c0) begin void'(mq.pop_front()); mhead = (mhead + 1) % 16; end
                if (c1) begin void'(mq.pop_front()); mhead = (mhead + 1) % 16; end
                if (issue_valid && sz < 16) begin
                    mq.push_back('{rd: issue_rd, typ: issue_type, pred: issue_pred,
                                   alt: issue_alt_pc, pcp: issue_pc[8:1],
                                   rdy: issue_done,
                                   val: issue_done ? issue_result : 32'd0});
                end
                if (mis) begin
                    mclear = 1'b1;
                    mnpc   = e_alt;
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic iss(input logic [31:0] pc, input logic done, input logic [31:0] res,
                       input logic [4:0] rd, input logic [1:0] ty, input logic pr,
                       input logic [31:0] alt);
        issue_valid  = 1'b1;
        issue_pc     = pc;
        issue_done   = done;
        issue_result = res;
        issue_rd     = rd;
        issue_type   = ty;
        issue_pred   = pr;
        issue_alt_pc = alt;
        nxt();
        issue_valid  = 1'b0;
        issue_done   = 1'b0;
    endtask

    task automatic wb(input logic [1:0] v, input logic [3:0] id0, input logic [31:0] v0,
                      input logic [3:0] id1, input logic [31:0] v1);
        wb_valid = v;
        wb_id    = {id1, id0};
        wb_val   = {v1, v0};
    endtask

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        issue_valid = 0; issue_pc = 0; issue_done = 0; issue_result = 0;
        issue_rd = 0; issue_type = 0; issue_pred = 0; issue_alt_pc = 0;
        wb_valid = 0; wb_id = 0; wb_val = 0; q_id = 0;
        repeat (2) @(posedge clk);
        #1 rst_in = 1'b0;
        smp();
        chk("lit_rst_empty", 64'(rob_empty), 64'd1);
        chk("lit_rst_free", 64'(rob_free_id), 64'd0);
        nxt();

        // dual commit
        iss(32'h1000, 0, 0, 5'd3, 2'b01, 0, 0);
        iss(32'h1004, 0, 0, 5'd4, 2'b01, 0, 0);
        wb(2'b11, 4'd0, 32'h11, 4'd1, 32'h22);
        nxt();
        wb(2'b00, 0, 0, 0, 0);
        smp();
        chk("lit_dual_valid", 64'(cm_valid), 64'd3);
        chk("lit_dual_rd", 64'(cm_rd), 64'({5'd4, 5'd3}));
        chk("lit_dual_val", cm_val, 64'h00000022_00000011);
        chk("lit_dual_id", 64'(cm_id), 64'h10);
        nxt();
        smp();
        chk("lit_dual_head", 64'(rob_head_id), 64'd2);
        nxt();

        // bypass and writeback collision
        for (int i = 0; i < 4; i++) iss(32'h1100, 0, 0, 5'(8 + i), 2'b01, 0, 0);
        wb(2'b10, 4'd0, 0, 4'd5, 32'hAB);
        q_id = {4'd2, 4'd5};
        smp();
        chk("lit_byp_avail0", 64'(q_avail[0]), 64'd1);
        chk("lit_byp_val0", 64'(q_val[31:0]), 64'hAB);
        chk("lit_byp_avail1", 64'(q_avail[1]), 64'd0);
        nxt();
        wb(2'b11, 4'd4, 32'h40, 4'd4, 32'h41);
        q_id = {4'd2, 4'd4};
        smp();
        chk("lit_byp_lowport", 64'(q_val[31:0]), 64'h40);
        nxt();
        wb(2'b00, 0, 0, 0, 0);
        smp();
        chk("lit_byp_stored", 64'(q_val[31:0]), 64'h41);
        nxt();
        wb(2'b11, 4'd2, 32'h20, 4'd3, 32'h30);
        nxt();
        wb(2'b00, 0, 0, 0, 0);
        smp();
        chk("lit_c23_val", cm_val, 64'h00000030_00000020);
        nxt();
        smp();
        chk("lit_c45_val", cm_val, 64'h000000AB_00000041);
        chk("lit_c45_rd", 64'(cm_rd), 64'({5'd11, 5'd10}));
        nxt();

        // correctly predicted branches
        iss(32'h3000, 1, 32'h66, 5'd7, 2'b01, 0, 0);
        iss(32'h2046, 0, 0, 5'd0, 2'b10, 0, 32'h300);
        wb(2'b01, 4'd7, 32'h0, 0, 0);
        nxt();
        wb(2'b00, 0, 0, 0, 0);
        smp();
        chk("lit_br_valid", 64'(br_valid), 64'd1);
        chk("lit_br_pcp", 64'(br_pc_part), 64'h23);
        chk("lit_br_rd", 64'(cm_rd), 64'd0);
        nxt();
        iss(32'h3010, 0, 0, 5'd7, 2'b01, 0, 0);
        iss(32'h3014, 0, 0, 5'd0, 2'b10, 1, 32'h400);
        wb(2'b11, 4'd8, 32'h88, 4'd9, 32'h1);
        nxt();
        wb(2'b00, 0, 0, 0, 0);
        smp();
        chk("lit_br_slot1", 64'(cm_valid), 64'd3);
        chk("lit_br_taken", 64'(br_taken), 64'd1);
        nxt();
        smp();
        chk("lit_br_noclr", 64'(rob_clear), 64'd0);
        nxt();

        // mispredict
        iss(32'h2046, 0, 0, 5'd0, 2'b10, 1, 32'h100);
        iss(32'h2048, 1, 32'h99, 5'd6, 2'b01, 0, 0);
        wb(2'b01, 4'd10, 32'h0, 0, 0);
        nxt();
        wb(2'b00, 0, 0, 0, 0);
        smp();
        chk("lit_mis_br", 64'(br_valid), 64'd1);
        chk("lit_mis_slot", 64'(cm_valid), 64'd1);
        nxt();
        issue_valid = 1'b1; issue_done = 1'b1; issue_rd = 5'd9; issue_type = 2'b01;
        wb(2'b01, 4'd11, 32'h5, 0, 0);
        smp();
        chk("lit_mis_clear", 64'(rob_clear), 64'd1);
        chk("lit_mis_pc", 64'(new_pc), 64'h100);
        chk("lit_mis_nocm", 64'(cm_valid), 64'd0);
        nxt();
        issue_valid = 1'b0; issue_done = 1'b0;
        wb(2'b00, 0, 0, 0, 0);
        smp();
        chk("lit_mis_empty", 64'(rob_empty), 64'd1);
        chk("lit_mis_free", 64'(rob_free_id), 64'd0);
        nxt();

        // fill, overflow drop, wrap
        for (int i = 0; i < 17; i++) begin
            issue_valid = 1'b1; issue_done = 1'b0;
            issue_rd = 5'(i); issue_type = 2'b01;
            smp();
            chk("lit_fill_full", 64'(rob_full), 64'(i >= 13));
            nxt();
        end
        issue_valid = 1'b0;
        smp();
        chk("lit_fill_full16", 64'(rob_full), 64'd1);
        chk("lit_fill_wrap", 64'(rob_free_id), 64'd0);
        nxt();

        // freeze with rdy_in low
        wb(2'b01, 4'd0, 32'h5A5A, 0, 0);
        nxt();
        wb(2'b00, 0, 0, 0, 0);
        rdy_in = 1'b0;
        smp();
        chk("lit_frz_cm", 64'(cm_valid), 64'd0);
        chk("lit_frz_full", 64'(rob_full), 64'd0);
        nxt();
        smp();
        chk("lit_frz_head", 64'(rob_head_id), 64'd0);
        nxt();
        rdy_in = 1'b1;
        smp();
        chk("lit_res_cm", 64'(cm_valid), 64'd1);
        chk("lit_res_val", 64'(cm_val[31:0]), 64'h5A5A);
        nxt();

        // asynchronous reset with live entries
        wb(2'b01, 4'd1, 32'h1, 0, 0);
        nxt();
        wb(2'b00, 0, 0, 0, 0);
        smp();
        chk("lit_pre_rst_cm", 64'(cm_valid), 64'd1);
        rst_in = 1'b1;
        #1;
        chk("lit_arst_empty", 64'(rob_empty), 64'd1);
        chk("lit_arst_free", 64'(rob_free_id), 64'd0);
        chk("lit_arst_cm", 64'(cm_valid), 64'd0);
        nxt();
        nxt();
        rst_in = 1'b0;
        smp();
        chk("lit_post_rst", 64'(rob_empty), 64'd1);
        nxt();
        nxt();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
